// File: rtl/bus_arbiter_2m.sv
// Two-master system bus arbiter with registered grants, latched slave select and watchdog release.
// Optional macro ROUND_ROBIN_EN: ties in IDLE alternate using last_owner; otherwise master 1 wins ties.
module bus_arbiter_2m #(
    parameter int unsigned SLAVE_LEN      = 2,
    parameter int unsigned TIMEOUT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_req,
    input  logic                 m2_req,
    input  logic [SLAVE_LEN-1:0] m1_slave_sel,
    input  logic [SLAVE_LEN-1:0] m2_slave_sel,
    input  logic                 trans_done,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 bus_busy,
    output logic                 master_sel,
    output logic [SLAVE_LEN-1:0] slave_select,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT1  = 2'd1,
        GRANT2  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [TIMEOUT_LEN-1:0] TIMEOUT_LAST = TIMEOUT_LEN'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_nx;
    logic [TIMEOUT_LEN-1:0] count, count_nx;
    logic                   last_owner, last_owner_nx;   // 0 = master 1, 1 = master 2
    logic                   master_sel_nx;
    logic [SLAVE_LEN-1:0]   slave_select_nx;
    logic                   timeout_nx;
    logic                   owner_req;
    logic                   tie_to_m2;

`ifdef ROUND_ROBIN_EN
    assign tie_to_m2 = ~last_owner;
`else
    assign tie_to_m2 = 1'b0;
`endif

    always_comb begin
        state_nx        = state;
        count_nx        = count;
        last_owner_nx   = last_owner;
        master_sel_nx   = master_sel;
        slave_select_nx = slave_select;
        timeout_nx      = 1'b0;
        owner_req       = 1'b0;

        case (state)
            IDLE: begin
                if (m1_req && !(m2_req && tie_to_m2)) begin
                    state_nx        = GRANT1;
                    master_sel_nx   = 1'b0;
                    slave_select_nx = m1_slave_sel;
                    count_nx        = '0;
                end else if (m2_req) begin
                    state_nx        = GRANT2;
                    master_sel_nx   = 1'b1;
                    slave_select_nx = m2_slave_sel;
                    count_nx        = '0;
                end
            end

            GRANT1, GRANT2: begin
                owner_req = (state == GRANT1) ? m1_req : m2_req;
                // Priority: completion, then abandon, then watchdog.
                if (trans_done || !owner_req) begin
                    state_nx      = RELEASE;
                    last_owner_nx = (state == GRANT2);
                end else if (count == TIMEOUT_LAST) begin
                    state_nx      = RELEASE;
                    last_owner_nx = (state == GRANT2);
                    timeout_nx    = 1'b1;
                end else begin
                    count_nx = count + TIMEOUT_LEN'(1);
                end
            end

            RELEASE: state_nx = IDLE;

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            last_owner   <= 1'b1;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            bus_busy     <= 1'b0;
            master_sel   <= 1'b0;
            slave_select <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            last_owner   <= last_owner_nx;
            m1_grant     <= (state_nx == GRANT1);
            m2_grant     <= (state_nx == GRANT2);
            bus_busy     <= (state_nx == GRANT1) || (state_nx == GRANT2);
            master_sel   <= master_sel_nx;
            slave_select <= slave_select_nx;
            timeout_err  <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Randomized and directed bench for bus_arbiter_2m against a transaction-level ownership model.
module tb_bus_arbiter_2m;

    localparam int unsigned SLAVE_LEN      = 2;
    localparam int unsigned TIMEOUT_LEN    = 8;
    localparam int unsigned TIMEOUT_CYCLES = 200;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 m1_req, m2_req;
    logic [SLAVE_LEN-1:0] m1_slave_sel, m2_slave_sel;
    logic                 trans_done;
    logic                 m1_grant, m2_grant, bus_busy, master_sel, timeout_err;
    logic [SLAVE_LEN-1:0] slave_select;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, how long, and whether a dead cycle is pending.
    int                   own;      // 0 none, 1 master 1, 2 master 2
    int                   held;     // grant cycles already completed by current owner
    bit                   dead;
    int                   prev_own;
    bit                   e_msel;
    logic [SLAVE_LEN-1:0] e_ssel;
    bit                   e_terr;

    bus_arbiter_2m #(
        .SLAVE_LEN     (SLAVE_LEN),
        .TIMEOUT_LEN   (TIMEOUT_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m1_req      (m1_req),
        .m2_req      (m2_req),
        .m1_slave_sel(m1_slave_sel),
        .m2_slave_sel(m2_slave_sel),
        .trans_done  (trans_done),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .bus_busy    (bus_busy),
        .master_sel  (master_sel),
        .slave_select(slave_select),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        int who;
        bit still;
        e_terr = 1'b0;
        if (reset) begin
            own = 0; held = 0; dead = 1'b0; prev_own = 2;
            e_msel = 1'b0; e_ssel = '0;
        end else if (own != 0) begin
            still = (own == 1) ? m1_req : m2_req;
            if (trans_done || !still || held == int'(TIMEOUT_CYCLES) - 1) begin
                e_terr   = !trans_done && still;
                prev_own = own;
                own      = 0;
                dead     = 1'b1;
            end else begin
                held++;
            end
        end else if (dead) begin
            dead = 1'b0;
        end else if (m1_req || m2_req) begin
            if (m1_req && m2_req) begin
`ifdef ROUND_ROBIN_EN
                who = (prev_own == 1) ? 2 : 1;
`else
                who = 1;
`endif
            end else begin
                who = m1_req ? 1 : 2;
            end
            own    = who;
            held   = 0;
            e_msel = (who == 2);
            e_ssel = (who == 1) ? m1_slave_sel : m2_slave_sel;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".m1_grant"},  32'(m1_grant),     32'(own == 1));
        check_eq({tag, ".m2_grant"},  32'(m2_grant),     32'(own == 2));
        check_eq({tag, ".bus_busy"},  32'(bus_busy),     32'(own != 0));
        check_eq({tag, ".master_sel"},32'(master_sel),   32'(e_msel));
        check_eq({tag, ".slave_sel"}, 32'(slave_select), 32'(e_ssel));
        check_eq({tag, ".timeout"},   32'(timeout_err),  32'(e_terr));
        check_eq({tag, ".exclusive"}, 32'(m1_grant & m2_grant), 32'(0));
    endtask

    // Called at a negedge: drive, let one rising edge happen, then compare mid-cycle.
    task automatic drive_cycle(input string tag, input logic rst, input logic r1, input logic r2,
                               input logic [SLAVE_LEN-1:0] s1, input logic [SLAVE_LEN-1:0] s2,
                               input logic td);
        reset = rst; m1_req = r1; m2_req = r2;
        m1_slave_sel = s1; m2_slave_sel = s2; trans_done = td;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    int timeout_pulses;

    initial begin
        reset = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
        m1_slave_sel = '0; m2_slave_sel = '0; trans_done = 1'b0;
        own = 0; held = 0; dead = 1'b0; prev_own = 2; e_msel = 1'b0; e_ssel = '0; e_terr = 1'b0;
        @(negedge clk);

        repeat (2) drive_cycle("reset", 1, 1, 1, 2'd3, 2'd1, 1);

        // Single master 1 transaction, done on the fifth edge
        for (int i = 1; i <= 4; i++) drive_cycle("m1_basic", 0, 1, 0, 2'd2, 2'd0, 0);
        check_eq("m1_basic.slave_select_2", 32'(slave_select), 32'd2);
        drive_cycle("m1_done", 0, 1, 0, 2'd1, 2'd0, 1);
        drive_cycle("m1_gap", 0, 0, 0, 2'd1, 2'd0, 0);

        // Stray done with nobody requesting
        repeat (3) drive_cycle("stray_done", 0, 0, 0, 2'd3, 2'd3, 1);

        // Both masters held, done every fourth cycle
        for (int i = 0; i < 24; i++)
            drive_cycle("tie", 0, 1, 1, 2'd1, 2'd2, (i % 4) == 3);
        drive_cycle("tie_end", 0, 0, 0, 2'd0, 2'd0, 0);
        drive_cycle("tie_end", 0, 0, 0, 2'd0, 2'd0, 0);

        // Master 2 holds with no completion until the watchdog fires
        timeout_pulses = 0;
        for (int i = 0; i < int'(TIMEOUT_CYCLES) + 6; i++) begin
            drive_cycle("timeout", 0, 0, 1, 2'd0, 2'(i), 0);
            if (timeout_err) timeout_pulses++;
        end
        check_eq("timeout.pulse_count", 32'(timeout_pulses), 32'd1);
        drive_cycle("timeout_end", 0, 0, 0, 2'd0, 2'd0, 0);
        drive_cycle("timeout_end", 0, 0, 0, 2'd0, 2'd0, 0);

        // Master 1 abandons while master 2 waits
        for (int i = 0; i < 3; i++) drive_cycle("abandon", 0, 1, 1, 2'd1, 2'd3, 0);
        for (int i = 0; i < 5; i++) drive_cycle("abandon_m2", 0, 0, 1, 2'd1, 2'd3, 0);
        drive_cycle("abandon_end", 0, 0, 0, 2'd0, 2'd0, 1);
        drive_cycle("abandon_end", 0, 0, 0, 2'd0, 2'd0, 0);

        // Reset in the middle of a master 2 grant, then a tie
        for (int i = 0; i < 52; i++) drive_cycle("mid_reset", 0, 0, 1, 2'd0, 2'd2, 0);
        drive_cycle("mid_reset_hit", 1, 0, 1, 2'd0, 2'd2, 0);
        for (int i = 0; i < 4; i++) drive_cycle("post_reset_tie", 0, 1, 1, 2'd2, 2'd1, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            drive_cycle("random",
                        ($urandom_range(0, 299) == 0),
                        ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 3) != 0),
                        2'($urandom), 2'($urandom),
                        ($urandom_range(0, 99) < 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
